// File: rtl/aes_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the AES ShiftRows/MixColumns stage.
// State packing is row-major: row r occupies [127-32r -: 32], column 0 is the high byte of a row.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } smc_state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] st_byte(input aes_state_t s, input int r, input int c);
    return s[127-8*(4*r+c) -: 8];
  endfunction

  // Row r rotated left by r bytes.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = st_byte(s, r, (c + r) % 4);
    return o;
  endfunction

  // Row r rotated right by r bytes.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = st_byte(s, r, (c + 4 - r) % 4);
    return o;
  endfunction

  function automatic aes_word_t get_col(input aes_state_t s, input int c);
    return {st_byte(s, 0, c), st_byte(s, 1, c), st_byte(s, 2, c), st_byte(s, 3, c)};
  endfunction

  function automatic aes_state_t set_col(input aes_state_t s, input int c, input aes_word_t w);
    aes_state_t o;
    o = s;
    for (int r = 0; r < 4; r++)
      o[127-8*(4*r+c) -: 8] = w[31-8*r -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational single-column MixColumns; byte [31:24] is row 0.
// Inverse matrix exists only when AES_SMC_INV_EN is defined, otherwise inv_i is ignored.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd_w;

  assign {a0, a1, a2, a3} = col_i;

  // 3*x expressed as xtime(x)^x.
  assign fwd_w = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};

`ifdef AES_SMC_INV_EN
  logic [31:0] inv_w;

  assign inv_w = {gf_mul(a0, 8'h0E) ^ gf_mul(a1, 8'h0B) ^ gf_mul(a2, 8'h0D) ^ gf_mul(a3, 8'h09),
                  gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0E) ^ gf_mul(a2, 8'h0B) ^ gf_mul(a3, 8'h0D),
                  gf_mul(a0, 8'h0D) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0E) ^ gf_mul(a3, 8'h0B),
                  gf_mul(a0, 8'h0B) ^ gf_mul(a1, 8'h0D) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0E)};
  assign col_o = inv_i ? inv_w : fwd_w;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = fwd_w;
`endif

endmodule

// File: rtl/aes_shift_mix_seq.sv
// Iterative ShiftRows+MixColumns stage: one column mixed per clock, result after 5 edges.
// Holds the result until out_ready; optional inverse path under AES_SMC_INV_EN.
module aes_shift_mix_seq
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_final,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  smc_state_e      state_q;
  logic [CW-1:0]   col_q;
  aes_state_t      work_q;
  logic            final_q;
  logic            inv_q;
  logic            in_ready_q;
  logic            out_valid_q;
  aes_state_t      out_state_q;

  logic            inv_sel;
  aes_state_t      sr_d;
  aes_word_t       col_cur;
  aes_word_t       col_mix;
  aes_word_t       col_d;

`ifdef AES_SMC_INV_EN
  assign inv_sel = in_inv;
  assign sr_d    = inv_sel ? inv_shift_rows(in_state) : shift_rows(in_state);
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign inv_sel       = 1'b0;
  assign sr_d          = shift_rows(in_state);
`endif

  assign col_cur = get_col(work_q, int'(col_q));

  aes_mix_column u_mix (
    .col_i (col_cur),
    .inv_i (inv_q),
    .col_o (col_mix)
  );

  assign col_d = final_q ? col_cur : col_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      work_q      <= '0;
      final_q     <= 1'b0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            work_q     <= sr_d;
            final_q    <= in_final;
            inv_q      <= inv_sel;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MIX;
          end
        end
        MIX: begin
          work_q <= set_col(work_q, int'(col_q), col_d);
          col_q  <= col_q + CW'(1);
          if (col_q == CW'(NCOL - 1)) state_q <= HOLD;
        end
        HOLD: begin
          // First HOLD cycle loads the output register; it then stays frozen until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_state_q <= work_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_aes_shift_mix_seq.sv
// Scoreboard bench for aes_shift_mix_seq: driver pushes expected results, monitor pops on output handshakes.
module tb_aes_shift_mix_seq;

  localparam int NCOL = 4;
`ifdef AES_SMC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] V1   = 128'hd4e0b81e_27bfb441_11985d52_aef1e530;
  localparam logic [127:0] E1   = 128'h04e04828_66cbf806_8119d326_e59a7a4c;
  localparam logic [127:0] V2   = 128'h49457f77_dedb3902_d2968753_89f11a3b;
  localparam logic [127:0] E2   = 128'h581bdb1b_4d4be76b_ca5acab0_f1aca8e5;
  localparam logic [127:0] E1FN = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_final = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  int           acc_neg_q[$];
  int           neg_idx = 0;
  int           acc_neg = -100;
  int           hs_neg  = -100;
  int           hs_cnt  = 0;
  logic         prev_ov = 1'b0;
  logic         prev_hs = 1'b0;
  logic [127:0] prev_os = '0;

  always #5 clk = ~clk;

  aes_shift_mix_seq #(.NCOL(NCOL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_final  (in_final),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model on a 4x4 byte matrix with integer GF(2^8) arithmetic.
  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) == 1) p = p ^ x;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11B;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit fin, input bit inv);
    int m[4][4];
    int t[4][4];
    int fwd[4];
    int bwd[4];
    int acc;
    logic [127:0] res;
    fwd = '{2, 3, 1, 1};
    bwd = '{14, 11, 13, 9};
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = int'(s[127-8*(4*r+c) -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = inv ? m[r][(c + 4 - r) % 4] : m[r][(c + r) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(inv ? bwd[(k + 4 - r) % 4] : fwd[(k + 4 - r) % 4], t[k][c]);
        res[127-8*(4*r+c) -: 8] = 8'(fin ? t[r][c] : acc);
      end
    return res;
  endfunction

  // Monitor: all output-side checks happen on the falling edge.
  always @(negedge clk) begin
    neg_idx++;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_neg_q.push_back(neg_idx);
        acc_neg = neg_idx;
      end
      if (out_valid) check_int("in_ready_low_in_hold", int'(in_ready), 0);
      if (out_valid && !prev_ov) begin
        // 6 falling edges between accept-sample and first valid-sample = 5 rising edges.
        if (acc_neg_q.size() == 0) check_int("spurious_out_valid", 1, 0);
        else check_int("latency", neg_idx - acc_neg_q.pop_front(), 6);
      end
      if (out_valid && prev_ov && !prev_hs) check_vec("hold_stable", out_state, prev_os);
      if (out_valid && out_ready) begin
        hs_neg = neg_idx;
        hs_cnt++;
        if (exp_q.size() == 0) check_int("unexpected_output", 1, 0);
        else check_vec("out_state", out_state, exp_q.pop_front());
      end
      prev_ov = out_valid;
      prev_os = out_state;
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic drive(input logic [127:0] s, input bit fin, input bit inv);
    in_valid = 1'b1;
    in_state = s;
    in_final = fin;
    in_inv   = inv;
  endtask

  task automatic wait_accept(input logic [127:0] expv, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check_int({name, "_accept_timeout"}, 0, 1);
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      exp_q.push_back(expv);
      #1;
    end
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_final = 1'($urandom_range(0, 1));
    in_inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_hs(input int target, input bit rand_rdy);
    int n = 0;
    while (hs_cnt < target && n < 300) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    if (hs_cnt < target) check_int("output_timeout", hs_cnt, target);
    out_ready = 1'b1;
  endtask

  task automatic wait_out_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check_int("out_valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_vec("rst_out_state", out_state, '0);
    check_int("rst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    acc_neg_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_int("post_rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int tgt;
    logic [127:0] s;
    bit fin;
    bit inv;

    #1 rst_n = 1'b0;
    #1;
    check_int("init_in_ready", int'(in_ready), 0);
    check_int("init_out_valid", int'(out_valid), 0);
    check_vec("init_out_state", out_state, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_int("idle_in_ready", int'(in_ready), 1);

    // Directed FIPS-197 vectors.
    out_ready = 1'b1;
    tgt = hs_cnt + 1; drive(V1, 1'b0, 1'b0); wait_accept(E1, "fwd1");  wait_hs(tgt, 1'b0);
    tgt = hs_cnt + 1; drive(V2, 1'b0, 1'b0); wait_accept(E2, "fwd2");  wait_hs(tgt, 1'b0);
    tgt = hs_cnt + 1; drive(V1, 1'b1, 1'b0); wait_accept(E1FN, "fin"); wait_hs(tgt, 1'b0);

    // Backpressure with a second state waiting upstream.
    out_ready = 1'b0;
    tgt = hs_cnt + 2;
    drive(V1, 1'b0, 1'b0);
    wait_accept(E1, "bp_a");
    drive(V2, 1'b0, 1'b0);
    wait_out_valid();
    repeat (7) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept(E2, "bp_b");
    check_int("accept_after_out_hs", acc_neg - hs_neg, 1);
    wait_hs(tgt, 1'b0);

    // Reset during MIX at col=2, then recompute.
    drive(V2, 1'b0, 1'b0);
    wait_accept(E2, "rst_mix");
    repeat (2) @(posedge clk);
    #2;
    pulse_reset();
    tgt = hs_cnt + 1; drive(V1, 1'b1, 1'b0); wait_accept(E1FN, "after_rst"); wait_hs(tgt, 1'b0);

    // Reset while holding a valid result.
    out_ready = 1'b0;
    drive(V1, 1'b0, 1'b0);
    wait_accept(E1, "rst_hold");
    wait_out_valid();
    #2;
    pulse_reset();
    out_ready = 1'b1;

    // Inverse request: functional only when the inverse path is built in.
    tgt = hs_cnt + 1; drive(E1, 1'b0, 1'b1); wait_accept(model(E1, 1'b0, INV_EN), "inv"); wait_hs(tgt, 1'b0);
    tgt = hs_cnt + 1; drive(E1, 1'b1, 1'b1); wait_accept(model(E1, 1'b1, INV_EN), "inv_fin"); wait_hs(tgt, 1'b0);

    // Randomised traffic with random downstream stalls.
    for (int i = 0; i < 30; i++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      fin = ($urandom_range(0, 3) == 0);
      inv = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      tgt = hs_cnt + 1;
      drive(s, fin, inv);
      wait_accept(model(s, fin, inv & INV_EN), "rand");
      wait_hs(tgt, 1'b1);
    end

    repeat (3) @(posedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
